// File: rtl/noc_input_unit_pkg.sv
// Shared NoC types, flit layout helpers and the XY dimension-order route function
// used by the router input stage.
package noc_input_unit_pkg;

    localparam int unsigned CoordWidth       = 4;
    localparam int unsigned MessageTypeWidth = 4;
    localparam int unsigned PortQueueDepth   = 4;
    localparam int unsigned DirWidth         = 5;

    typedef struct packed {
        logic [CoordWidth-1:0] x;
        logic [CoordWidth-1:0] y;
    } xy_t;

    localparam int unsigned XyWidth = $bits(xy_t);

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef logic [MessageTypeWidth-1:0] message_t;
    typedef logic [DirWidth-1:0]         direction_t;

    localparam direction_t goLocal = 5'b00001;
    localparam direction_t goNorth = 5'b00010;
    localparam direction_t goEast  = 5'b00100;
    localparam direction_t goSouth = 5'b01000;
    localparam direction_t goWest  = 5'b10000;

    typedef enum logic [2:0] {
        kLocalPort,
        kNorthPort,
        kEastPort,
        kSouthPort,
        kWestPort
    } noc_port_t;

    typedef enum logic {
        kFlowControlAckNack,
        kFlowControlCreditBased
    } noc_flow_control_t;

    typedef enum logic {
        kIdle,
        kBody
    } input_state_t;

    // Flit layout: preamble at the top, then source, destination and message type.
    function automatic int unsigned head_bit(int unsigned flit_width);
        return flit_width - 1;
    endfunction

    function automatic int unsigned tail_bit(int unsigned flit_width);
        return flit_width - 2;
    endfunction

    function automatic int unsigned src_lsb(int unsigned flit_width);
        return flit_width - 2 - XyWidth;
    endfunction

    function automatic int unsigned dst_lsb(int unsigned flit_width);
        return flit_width - 2 - 2 * XyWidth;
    endfunction

    function automatic int unsigned msg_lsb(int unsigned flit_width);
        return flit_width - 2 - 2 * XyWidth - MessageTypeWidth;
    endfunction

    function automatic direction_t get_onehot_port(noc_port_t port);
        case (port)
            kNorthPort: return goNorth;
            kEastPort:  return goEast;
            kSouthPort: return goSouth;
            kWestPort:  return goWest;
            default:    return goLocal;
        endcase
    endfunction

    // X first, then Y; north is decreasing y.
    function automatic direction_t xy_route(xy_t pos, xy_t dst);
        if (dst.x > pos.x)      return goEast;
        else if (dst.x < pos.x) return goWest;
        else if (dst.y < pos.y) return goNorth;
        else if (dst.y > pos.y) return goSouth;
        else                    return goLocal;
    endfunction

endpackage

// File: rtl/noc_input_unit_fifo.sv
// First-word fall-through FIFO; push is accepted at full when a pop happens in the same cycle.
module noc_input_unit_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CntW-1:0]  o_count
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CntW'(Depth));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

endmodule

// File: rtl/noc_input_unit.sv
// Router input port: flit FIFO, packet state machine, XY route lookup and
// upstream flow control (ack/nack stop or credit return).
module noc_input_unit
    import noc_input_unit_pkg::*;
#(
    parameter int unsigned       FlitWidth   = 64,
    parameter noc_port_t         PortId      = kLocalPort,
    parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
    parameter int unsigned       Depth       = PortQueueDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  xy_t                  position,
    input  logic [FlitWidth-1:0] data_in,
    input  logic                 data_void_in,
    output logic                 stop_out,
    output logic                 credit_out,
    output logic [FlitWidth-1:0] data_out,
    output logic                 valid_out,
    output direction_t           route_out,
    input  logic                 pop_in,
    output logic                 overflow_out,
    output logic                 error_out
);

    localparam int unsigned CntW    = $clog2(Depth + 1);
    localparam int unsigned HeadBit = head_bit(FlitWidth);
    localparam int unsigned TailBit = tail_bit(FlitWidth);
    localparam int unsigned DstLsb  = dst_lsb(FlitWidth);

    input_state_t    r_state;
    input_state_t    w_state_next;
    direction_t      r_route;
    direction_t      w_route_next;
    direction_t      w_calc_route;
    logic            r_stop;
    logic            r_credit;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_head;
    logic            w_tail;
    logic            w_uturn;
    xy_t             w_dst;
    logic [CntW-1:0] w_count;
    logic [CntW-1:0] w_count_next;

    noc_input_unit_fifo #(
        .Depth (Depth),
        .Width (FlitWidth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (data_in),
        .o_data  (data_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign valid_out    = !w_empty;
    assign w_pop        = pop_in && valid_out;
    assign w_push       = !data_void_in && (!w_full || w_pop);
    assign overflow_out = !data_void_in && w_full && !w_pop;
    assign w_count_next = w_count + CntW'(w_push) - CntW'(w_pop);

    assign w_head       = data_out[HeadBit];
    assign w_tail       = data_out[TailBit];
    assign w_dst        = data_out[DstLsb +: XyWidth];
    assign w_calc_route = xy_route(position, w_dst);
    assign w_uturn      = (w_calc_route == get_onehot_port(PortId)) && (PortId != kLocalPort);

    // One slot stays free for the flit already in flight while stop propagates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stop   <= 1'b0;
            r_credit <= 1'b0;
        end else begin
            r_stop   <= (FlowControl == kFlowControlAckNack) && (w_count_next >= CntW'(Depth - 1));
            r_credit <= (FlowControl == kFlowControlCreditBased) && w_pop;
        end
    end

    assign stop_out   = r_stop;
    assign credit_out = r_credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= kIdle;
            r_route <= goLocal;
        end else begin
            r_state <= w_state_next;
            r_route <= w_route_next;
        end
    end

    // A head flit always restarts the packet; a headless flit in IDLE is forwarded locally.
    always_comb begin
        w_state_next = r_state;
        w_route_next = r_route;
        route_out    = '0;
        error_out    = 1'b0;
        if (valid_out) begin
            if (w_head) begin
                route_out = w_calc_route;
                error_out = w_pop && ((r_state == kBody) || w_uturn);
                if (w_pop) begin
                    w_route_next = w_calc_route;
                    w_state_next = w_tail ? kIdle : kBody;
                end
            end else if (r_state == kBody) begin
                route_out = r_route;
                if (w_pop && w_tail) begin
                    w_state_next = kIdle;
                end
            end else begin
                route_out = goLocal;
                error_out = w_pop;
            end
        end
    end

endmodule

// File: tb/tb_noc_input_unit.sv
// Randomised and directed stimulus for two input units (credit/local and ack-nack/west)
// checked every cycle against a queue-based packet model.
module tb_noc_input_unit;
    import noc_input_unit_pkg::*;

    localparam int unsigned FW = 64;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    xy_t           position;
    logic [FW-1:0] data_in;
    logic          data_void_in;
    logic          pop_in;

    logic          stop_cr, credit_cr, valid_cr, ovf_cr, err_cr;
    logic [FW-1:0] dout_cr;
    direction_t    route_cr;
    logic          stop_an, credit_an, valid_an, ovf_an, err_an;
    logic [FW-1:0] dout_an;
    direction_t    route_an;

    always #5 clk = ~clk;

    noc_input_unit #(
        .FlitWidth   (FW),
        .PortId      (kLocalPort),
        .FlowControl (kFlowControlCreditBased),
        .Depth       (D)
    ) u_cr (
        .clk          (clk),
        .rst          (rst),
        .position     (position),
        .data_in      (data_in),
        .data_void_in (data_void_in),
        .stop_out     (stop_cr),
        .credit_out   (credit_cr),
        .data_out     (dout_cr),
        .valid_out    (valid_cr),
        .route_out    (route_cr),
        .pop_in       (pop_in),
        .overflow_out (ovf_cr),
        .error_out    (err_cr)
    );

    noc_input_unit #(
        .FlitWidth   (FW),
        .PortId      (kWestPort),
        .FlowControl (kFlowControlAckNack),
        .Depth       (D)
    ) u_an (
        .clk          (clk),
        .rst          (rst),
        .position     (position),
        .data_in      (data_in),
        .data_void_in (data_void_in),
        .stop_out     (stop_an),
        .credit_out   (credit_an),
        .data_out     (dout_an),
        .valid_out    (valid_an),
        .route_out    (route_an),
        .pop_in       (pop_in),
        .overflow_out (ovf_an),
        .error_out    (err_an)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;

    logic [FW-1:0] q[$];
    bit            m_body   = 1'b0;
    direction_t    m_route  = goLocal;
    bit            m_stop   = 1'b0;
    bit            m_credit = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Destination sits in bits [53:46]: x in the upper nibble, y in the lower.
    function automatic direction_t ref_route(input logic [FW-1:0] f);
        int dx, dy, px, py;
        dx = int'(f[53:50]);
        dy = int'(f[49:46]);
        px = int'(position.x);
        py = int'(position.y);
        if (dx > px)      return goEast;
        else if (dx < px) return goWest;
        else if (dy < py) return goNorth;
        else if (dy > py) return goSouth;
        return goLocal;
    endfunction

    function automatic logic [FW-1:0] mk(input bit h, input bit t, input int dx, input int dy);
        logic [FW-1:0] f;
        f         = {$urandom, $urandom};
        f[63]     = h;
        f[62]     = t;
        f[53:50]  = 4'(dx);
        f[49:46]  = 4'(dy);
        return f;
    endfunction

    task automatic step(input bit r, input bit v, input logic [FW-1:0] d, input bit p);
        bit            vld, hd, tl, pe, psh, err_base, uturn;
        direction_t    er;
        logic [FW-1:0] hf;
        @(posedge clk);
        #1;
        rst          = r;
        data_void_in = v;
        data_in      = d;
        pop_in       = p;
        #1;
        vld      = (q.size() > 0);
        hf       = vld ? q[0] : '0;
        hd       = hf[63];
        tl       = hf[62];
        er       = '0;
        if (vld) er = hd ? ref_route(hf) : (m_body ? m_route : goLocal);
        pe       = p && vld;
        psh      = !v && ((q.size() < D) || pe);
        err_base = pe && (hd ? m_body : !m_body);
        uturn    = pe && hd && (ref_route(hf) == goWest);

        chk("valid_cr", 64'(valid_cr), 64'(vld));
        chk("valid_an", 64'(valid_an), 64'(vld));
        if (vld) begin
            chk("data_cr", dout_cr, hf);
            chk("data_an", dout_an, hf);
        end
        chk("route_cr", 64'(route_cr), 64'(er));
        chk("route_an", 64'(route_an), 64'(er));
        chk("ovf_cr", 64'(ovf_cr), 64'(!v && !psh));
        chk("ovf_an", 64'(ovf_an), 64'(!v && !psh));
        chk("err_cr", 64'(err_cr), 64'(err_base));
        chk("err_an", 64'(err_an), 64'(err_base || uturn));
        chk("stop_cr", 64'(stop_cr), 64'(0));
        chk("stop_an", 64'(stop_an), 64'(m_stop));
        chk("credit_cr", 64'(credit_cr), 64'(m_credit));
        chk("credit_an", 64'(credit_an), 64'(0));

        if (r) begin
            q.delete();
            m_body   = 1'b0;
            m_route  = goLocal;
            m_stop   = 1'b0;
            m_credit = 1'b0;
        end else begin
            if (pe) begin
                if (hd) begin
                    m_route = ref_route(hf);
                    m_body  = !tl;
                end else if (m_body && tl) begin
                    m_body = 1'b0;
                end
                void'(q.pop_front());
            end
            if (psh) q.push_back(d);
            m_stop   = (q.size() >= D - 1);
            m_credit = pe;
        end
    endtask

    initial begin
        bit rr, vv, pp, hh, tt;
        int pop_pct;
        rst          = 1'b1;
        data_void_in = 1'b1;
        data_in      = '0;
        pop_in       = 1'b0;
        position     = '{x: 4'd2, y: 4'd3};
        repeat (2) @(posedge clk);
        step(1, 1, '0, 0);

        // single-flit packet routed east, credit returned after pop
        step(0, 0, mk(1, 1, 5, 3), 0);
        step(0, 1, '0, 0);
        step(0, 1, '0, 1);
        step(0, 1, '0, 0);

        // four-flit packet north, fill to full, overflow, push+pop at full, drain
        step(0, 0, mk(1, 0, 2, 1), 0);
        step(0, 0, mk(0, 0, 0, 0), 0);
        step(0, 0, mk(0, 0, 0, 0), 0);
        step(0, 0, mk(0, 1, 0, 0), 0);
        step(0, 0, mk(1, 1, 7, 7), 0);
        step(0, 0, mk(1, 1, 3, 3), 1);
        repeat (5) step(0, 1, '0, 1);

        // headless flit in IDLE, then a U-turn for the west port
        step(0, 0, mk(0, 1, 4, 4), 0);
        step(0, 1, '0, 1);
        step(0, 0, mk(1, 1, 0, 3), 0);
        step(0, 1, '0, 1);

        // reset mid-packet, then a fresh local packet
        step(0, 0, mk(1, 0, 2, 7), 0);
        step(0, 0, mk(0, 0, 0, 0), 0);
        step(1, 1, '0, 0);
        step(0, 0, mk(1, 1, 2, 3), 0);
        step(0, 1, '0, 1);
        step(0, 1, '0, 0);

        for (int seg = 0; seg < 16; seg++) begin
            pop_pct = $urandom_range(10, 90);
            for (int c = 0; c < 150; c++) begin
                rr = ($urandom_range(0, 299) == 0);
                vv = rr || ($urandom_range(0, 3) == 0);
                pp = !rr && ($urandom_range(0, 99) < pop_pct);
                hh = ($urandom_range(0, 9) < 4);
                tt = ($urandom_range(0, 9) < 4);
                step(rr, vv, mk(hh, tt, $urandom_range(0, 5), $urandom_range(0, 6)), pp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
